// File: rtl/mem_bank_scan_reader.sv
// mem_bank_scan_reader: walks every bank/address of a multi-bank memory and streams the words out tagged on ready/valid.
// Defining MEM_SCAN_READER_ABORT_EN adds an abort input that cancels a scan in flight.
module mem_bank_scan_reader #(
  parameter int NUM_BANKS    = 2,
  parameter int DEPTH        = 18,
  parameter int DATA_WIDTH   = 16,
  parameter int OUTPUT_DELAY = 1,
  parameter int BANK_WIDTH   = $clog2(NUM_BANKS),
  parameter int ADDR_WIDTH   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
`ifdef MEM_SCAN_READER_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  mem_reb,
  output logic [BANK_WIDTH-1:0] mem_bankb,
  output logic [ADDR_WIDTH-1:0] mem_addrb,
  input  logic [DATA_WIDTH-1:0] mem_dob,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [BANK_WIDTH-1:0] out_bank,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last
);
  localparam int FD = OUTPUT_DELAY + 2;
  localparam int CW = $clog2(FD + 1);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic                  v;
    logic                  last;
    logic [BANK_WIDTH-1:0] bank;
    logic [ADDR_WIDTH-1:0] addr;
  } tag_t;
  typedef struct packed {
    logic                  last;
    logic [BANK_WIDTH-1:0] bank;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } ent_t;
  state_t state, state_n;
  logic [BANK_WIDTH-1:0] bank_c, rd_bank;
  logic [ADDR_WIDTH-1:0] addr_c, rd_addr;
  tag_t tg [OUTPUT_DELAY+1];
  ent_t q [FD];
  ent_t q_sh [FD];
  logic [CW-1:0] count, infl;
  logic ab, addr_end, is_last, issue, push, pop;
`ifdef MEM_SCAN_READER_ABORT_EN
  assign ab = abort && (state == SCAN || state == DRAIN);
`else
  assign ab = 1'b0;
`endif
  // tg[0] is the memory read port itself; tg[OUTPUT_DELAY] lines up with mem_dob
  always_comb begin
    infl = '0;
    for (int i = 0; i <= OUTPUT_DELAY; i++) infl = infl + CW'(tg[i].v);
    q_sh[FD-1] = q[FD-1];
    for (int i = 0; i < FD - 1; i++) q_sh[i] = q[i+1];
  end
  always_comb begin
    rd_bank = (state == IDLE) ? '0 : bank_c;
    rd_addr = (state == IDLE) ? '0 : addr_c;
    addr_end = rd_addr == ADDR_WIDTH'(DEPTH - 1);
    is_last = addr_end && rd_bank == BANK_WIDTH'(NUM_BANKS - 1);
    pop = out_valid && out_ready;
    push = tg[OUTPUT_DELAY].v && !ab;
    issue = (state == IDLE) ? start : state == SCAN && !ab && int'(count) + int'(infl) - int'(pop) < FD;
    state_n = ab ? DONE : issue ? (is_last ? DRAIN : SCAN) :
              (state == DRAIN && pop && out_last) ? DONE : (state == DONE) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bank_c <= '0;
      addr_c <= '0;
      count <= '0;
      for (int i = 0; i <= OUTPUT_DELAY; i++) tg[i] <= '0;
      for (int i = 0; i < FD; i++) q[i] <= '0;
    end else begin
      if (issue) begin
        addr_c <= addr_end ? '0 : rd_addr + 1'b1;
        bank_c <= addr_end ? rd_bank + 1'b1 : rd_bank;
      end
      tg[0] <= issue ? {1'b1, is_last, rd_bank, rd_addr} : {2'b00, tg[0].bank, tg[0].addr};
      for (int i = 1; i <= OUTPUT_DELAY; i++) tg[i] <= ab ? '0 : tg[i-1];
      count <= ab ? '0 : count + CW'(push) - CW'(pop);
      for (int i = 0; i < FD; i++)
        if (push && int'(count) - int'(pop) == i)
          q[i] <= {tg[OUTPUT_DELAY].last, tg[OUTPUT_DELAY].bank, tg[OUTPUT_DELAY].addr, mem_dob};
        else if (pop) q[i] <= q_sh[i];
    end
  assign busy = state == SCAN || state == DRAIN;
  assign done = state == DONE;
  assign mem_reb = tg[0].v;
  assign mem_bankb = tg[0].bank;
  assign mem_addrb = tg[0].addr;
  assign out_valid = count != '0;
  assign out_data = q[0].data;
  assign out_bank = q[0].bank;
  assign out_addr = q[0].addr;
  assign out_last = out_valid && q[0].last;
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !(push && !pop && int'(count) == FD));
endmodule

// File: tb/tb_mem_bank_scan_reader.sv
// tb_mem_bank_scan_reader: three reader instances (read latency 0/1/2) each behind a latency-matched memory model,
// checked against the expected bank-major word order and timing.
module tb_mem_bank_scan_reader;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] start = '0, rdy = '1, ab = '0;
  logic [2:0] busy, done, reb, ov, ol, mb, ob;
  logic [2:0][4:0] ma, oa;
  logic [2:0][15:0] dob, od;
  logic [15:0] salt = '0;
  int total = 0, passed = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] word(input logic b, input logic [4:0] a);
    return salt ^ {10'd0, b, a};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_c
    localparam int DP = (g == 1) ? 4 : 18;
    logic [15:0] s1, s2;
    mem_bank_scan_reader #(.NUM_BANKS(2), .DEPTH(DP), .DATA_WIDTH(16), .OUTPUT_DELAY(g), .ADDR_WIDTH(5)) dut (
      .clk(clk), .reset_n(reset_n), .start(start[g]),
`ifdef MEM_SCAN_READER_ABORT_EN
      .abort(ab[g]),
`endif
      .busy(busy[g]), .done(done[g]), .mem_reb(reb[g]), .mem_bankb(mb[g]), .mem_addrb(ma[g]),
      .mem_dob(dob[g]), .out_valid(ov[g]), .out_ready(rdy[g]), .out_data(od[g]),
      .out_bank(ob[g]), .out_addr(oa[g]), .out_last(ol[g]));
    always @(posedge clk) begin
      s1 <= reb[g] ? word(mb[g], ma[g]) : 16'($urandom);
      s2 <= s1;
    end
    assign dob[g] = (g == 0) ? (reb[g] ? word(mb[g], ma[g]) : 16'hbad0) : (g == 1) ? s1 : s2;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] outs(input int g);
    return {31'd0, busy[g], done[g], reb[g], ov[g], ol[g], mb[g], ma[g], od[g], ob[g], oa[g]};
  endfunction

  // mode 0: always ready, 1: ready every third cycle, 2: random ready; rs>0 re-pulses start mid-scan and in DONE
  task automatic scan(input int g, input int mode, input int rs);
    int dp = (g == 1) ? 4 : 18;
    int n = 2 * dp;
    int k = 0, nreb = 0, first_v = -1, first_r = -1, last_c = -1, done_c = -1, ndone = 0, maxout = 0;
    logic pv = 1'b0, pr = 1'b1;
    logic [23:0] pvec = '0;
    @(negedge clk) start[g] = 1'b1;
    @(negedge clk) start[g] = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      start[g] = rs > 0 && (c == rs || done[g] === 1'b1);
      if (c == 1) chk("busy_after_start", busy[g], 1);
      if (reb[g]) begin
        nreb++;
        if (first_r < 0) first_r = c;
      end
      if (ov[g] && first_v < 0) first_v = c;
      if (pv && !pr) chk("hold_while_stalled", {ov[g], ol[g], ob[g], oa[g], od[g]}, pvec);
      rdy[g] = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 3 == 0) : 1'($urandom_range(0, 1));
      if (nreb - k > maxout) maxout = nreb - k;
      if (ov[g] && rdy[g]) begin
        chk("beat_in_range", k < n, 1);
        chk("beat_data", od[g], salt ^ 16'((k / dp) * 32 + k % dp));
        chk("beat_tag", {ob[g], oa[g]}, (k / dp) * 32 + k % dp);
        chk("beat_last", ol[g], k == n - 1);
        if (ol[g]) last_c = c;
        k++;
      end
      if (done[g]) begin
        ndone++;
        if (done_c < 0) done_c = c;
      end
      if (done_c >= 0 && c == done_c + 1) chk("idle_after_done", busy[g], 0);
      pv = ov[g];
      pr = rdy[g];
      pvec = {ov[g], ol[g], ob[g], oa[g], od[g]};
      if (done_c >= 0 && c >= done_c + 4) break;
      @(negedge clk);
    end
    start[g] = 1'b0;
    rdy[g] = 1'b1;
    chk("beat_count", k, n);
    chk("read_count", nreb, n);
    chk("done_pulses", ndone, 1);
    chk("done_after_last", done_c, last_c + 1);
    chk("first_reb_cycle", first_r, 1);
    chk("first_valid_cycle", first_v, 2 + g);
    chk("max_outstanding", maxout, g + 2);
    if (mode == 0) chk("full_throughput", last_c - first_v, n - 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) chk("reset_outputs", outs(g), 0);
    reset_n = 1'b1;
    @(negedge clk);
    scan(1, 0, 0);
    scan(1, 1, 0);
    salt = 16'($urandom);
    scan(0, 0, 0);
    scan(2, 0, 0);
    scan(2, 1, 0);
    scan(1, 0, 5);
    salt = 16'($urandom);
    rdy[1] = 1'b0;
    @(negedge clk) start[1] = 1'b1;
    @(negedge clk) start[1] = 1'b0;
    repeat (4) @(negedge clk);
    chk("valid_before_reset", ov[1], 1);
    #2 reset_n = 1'b0;
    #1 chk("async_reset_outputs", outs(1), 0);
    @(negedge clk) reset_n = 1'b1;
    rdy[1] = 1'b1;
    scan(1, 2, 0);
`ifdef MEM_SCAN_READER_ABORT_EN
    begin : abort_test
      int k = 0, nd = 0, nl = 0, nr = 0;
      @(negedge clk) start[1] = 1'b1;
      @(negedge clk) start[1] = 1'b0;
      for (int c = 0; c < 20 && k < 2; c++) begin
        if (ov[1]) k++;
        @(negedge clk);
      end
      chk("abort_two_beats", k, 2);
      rdy[1] = 1'b0;
      ab[1] = 1'b1;
      @(negedge clk) ab[1] = 1'b0;
      chk("abort_valid_drop", ov[1], 0);
      for (int c = 0; c < 10; c++) begin
        nd += int'(done[1]);
        nl += int'(ol[1]);
        nr += int'(reb[1]);
        @(negedge clk);
      end
      chk("abort_done_pulse", nd, 1);
      chk("abort_no_last", nl, 0);
      chk("abort_no_reads", nr, 0);
      rdy[1] = 1'b1;
    end
`endif
    for (int r = 0; r < 3; r++) begin
      salt = 16'($urandom);
      scan(r, 2, 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
